// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// PipeControlUnit -- registered decode/control stage of the pipelined core.
//
// Decodes OPCODE/FUNC of the instruction in ID and registers the resulting
// control bundle into the ID/EX boundary. Branches and jumps are resolved
// from the EX copy of the bundle. A taken branch or jump squashes the
// instruction currently sitting in ID. A return-address stack serves
// JAL/RET pairs.
//
// Optional feature macro: PIPE_CTRL_RAS_EN
//   defined   -> circular return-address stack of RAS_DEPTH entries with
//                sticky overflow/underflow flags
//   undefined -> ret_addr is a single register loaded by each committing
//                JAL; both sticky flags read 0
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   in_valid            ID holds a valid instruction
//   OPCODE, FUNC        instruction fields of the ID instruction
//   pc_plus1            PC+1 of the ID instruction
//   ALU_Z               ALU zero flag of the instruction in EX
//   stall               hold ID/EX register and RAS
//   out_valid           EX slot holds a valid instruction
//   ALU_OP ... RF_D_SEL registered datapath controls
//   PC_SEL              0=PC+1, 1=branch, 2=jump, 3=return (combinational)
//   flush               squash the instruction currently in ID
//   ret_addr            RET target (top of stack)
//   link_addr           registered pc_plus1 of the EX instruction
//   illegal             EX instruction was undecodable
//   ras_overflow/underflow  sticky stack error flags
// ---------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int ADDR_W    = 16,
    parameter int RAS_DEPTH = 8,
    parameter int ALU_OP_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [5:0]          OPCODE,
    input  logic [5:0]          FUNC,
    input  logic [ADDR_W-1:0]   pc_plus1,
    input  logic                ALU_Z,
    input  logic                stall,
    output logic                out_valid,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                RF_WE,
    output logic                DM_WE,
    output logic                A_SEL,
    output logic                B_SEL,
    output logic                DM_ADDR_SEL,
    output logic [1:0]          RD_SEL,
    output logic [1:0]          RF_D_SEL,
    output logic [1:0]          PC_SEL,
    output logic                flush,
    output logic [ADDR_W-1:0]   ret_addr,
    output logic [ADDR_W-1:0]   link_addr,
    output logic                illegal,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    // Control-flow class of an instruction, carried alongside the control
    // bundle so EX can resolve PC_SEL and drive the stack without re-decoding.
    typedef enum logic [2:0] {
        K_NONE,
        K_BEQ,
        K_BNE,
        K_JMP,
        K_JAL,
        K_RET
    } ctrl_kind_t;

    ctrl_kind_t          d_kind;
    ctrl_kind_t          ex_kind;
    logic [ALU_OP_W-1:0] d_alu_op;
    logic                d_rf_we;
    logic                d_dm_we;
    logic                d_a_sel;
    logic                d_b_sel;
    logic                d_dm_addr_sel;
    logic [1:0]          d_rd_sel;
    logic [1:0]          d_rf_d_sel;
    logic                d_illegal;
    logic [1:0]          pc_sel_c;
    logic                ras_commit;
    logic                ras_push;

    // Decode of the ID instruction. Everything defaults to "no effect" so an
    // undecodable instruction falls out with all enables low and only the
    // illegal flag raised. A_SEL is part of the bundle but no current
    // instruction selects the alternate A operand.
    always_comb begin
        d_kind        = K_NONE;
        d_alu_op      = '0;
        d_rf_we       = 1'b0;
        d_dm_we       = 1'b0;
        d_a_sel       = 1'b0;
        d_b_sel       = 1'b0;
        d_dm_addr_sel = 1'b0;
        d_rd_sel      = 2'd0;
        d_rf_d_sel    = 2'd0;
        d_illegal     = 1'b0;
        case (OPCODE[5:4])
            2'd0: begin
                if (FUNC <= 6'd8) begin
                    d_rf_we  = 1'b1;
                    d_alu_op = ALU_OP_W'(FUNC);
                end else begin
                    d_illegal = 1'b1;
                end
            end
            2'd2: begin
                case (OPCODE[3:0])
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                        d_rf_we  = 1'b1;
                        d_b_sel  = 1'b1;
                        d_rd_sel = 2'd1;
                        case (OPCODE[3:0])
                            4'd5:    d_alu_op = ALU_OP_W'(9);
                            4'd6:    d_alu_op = ALU_OP_W'(10);
                            default: d_alu_op = ALU_OP_W'(OPCODE[3:0]);
                        endcase
                    end
                    4'd7: begin
                        d_rf_we    = 1'b1;
                        d_rd_sel   = 2'd1;
                        d_rf_d_sel = 2'd1;
                        d_alu_op   = ALU_OP_W'(11);
                    end
                    4'd8: begin
                        d_dm_we  = 1'b1;
                        d_alu_op = ALU_OP_W'(12);
                    end
                    4'd9: begin
                        d_rf_we       = 1'b1;
                        d_b_sel       = 1'b1;
                        d_rd_sel      = 2'd1;
                        d_rf_d_sel    = 2'd1;
                        d_dm_addr_sel = 1'b1;
                        d_alu_op      = ALU_OP_W'(13);
                    end
                    4'd10: begin
                        d_dm_we       = 1'b1;
                        d_dm_addr_sel = 1'b1;
                        d_alu_op      = ALU_OP_W'(14);
                    end
                    4'd11: begin
                        d_kind   = K_BEQ;
                        d_alu_op = ALU_OP_W'(1);
                    end
                    4'd12: begin
                        d_kind   = K_BNE;
                        d_alu_op = ALU_OP_W'(1);
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            2'd1: begin
                case (OPCODE[3:0])
                    4'd0: d_kind = K_JMP;
                    4'd1: begin
                        d_kind     = K_JAL;
                        d_rf_we    = 1'b1;
                        d_rd_sel   = 2'd2;
                        d_rf_d_sel = 2'd2;
                        d_alu_op   = ALU_OP_W'(16);
                    end
                    4'd2: begin
                        d_kind   = K_RET;
                        d_alu_op = ALU_OP_W'(17);
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // ID/EX boundary register. A stall freezes it entirely; a missing ID
    // instruction or a flush from EX loads a bubble so the wrong-path
    // instruction never reaches EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            ALU_OP      <= '0;
            RF_WE       <= 1'b0;
            DM_WE       <= 1'b0;
            A_SEL       <= 1'b0;
            B_SEL       <= 1'b0;
            DM_ADDR_SEL <= 1'b0;
            RD_SEL      <= 2'd0;
            RF_D_SEL    <= 2'd0;
            link_addr   <= '0;
            illegal     <= 1'b0;
            ex_kind     <= K_NONE;
        end else if (!stall) begin
            if (!in_valid || flush) begin
                out_valid   <= 1'b0;
                ALU_OP      <= '0;
                RF_WE       <= 1'b0;
                DM_WE       <= 1'b0;
                A_SEL       <= 1'b0;
                B_SEL       <= 1'b0;
                DM_ADDR_SEL <= 1'b0;
                RD_SEL      <= 2'd0;
                RF_D_SEL    <= 2'd0;
                link_addr   <= '0;
                illegal     <= 1'b0;
                ex_kind     <= K_NONE;
            end else begin
                out_valid   <= 1'b1;
                ALU_OP      <= d_alu_op;
                RF_WE       <= d_rf_we;
                DM_WE       <= d_dm_we;
                A_SEL       <= d_a_sel;
                B_SEL       <= d_b_sel;
                DM_ADDR_SEL <= d_dm_addr_sel;
                RD_SEL      <= d_rd_sel;
                RF_D_SEL    <= d_rf_d_sel;
                link_addr   <= pc_plus1;
                illegal     <= d_illegal;
                ex_kind     <= d_kind;
            end
        end
    end

    // Branch/jump resolution for the EX instruction. Nothing redirects the
    // PC while EX is empty or the pipe is stalled, which also keeps flush low.
    always_comb begin
        pc_sel_c = 2'd0;
        if (out_valid && !stall) begin
            case (ex_kind)
                K_BEQ:        pc_sel_c = ALU_Z  ? 2'd1 : 2'd0;
                K_BNE:        pc_sel_c = !ALU_Z ? 2'd1 : 2'd0;
                K_JMP, K_JAL: pc_sel_c = 2'd2;
                K_RET:        pc_sel_c = 2'd3;
                default:      pc_sel_c = 2'd0;
            endcase
        end
    end

    assign PC_SEL     = pc_sel_c;
    assign flush      = (pc_sel_c != 2'd0);
    assign ras_commit = out_valid && !stall;
    assign ras_push   = ras_commit && (ex_kind == K_JAL);

`ifdef PIPE_CTRL_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_pop;

    assign ras_pop = ras_commit && (ex_kind == K_RET);
    assign ras_top = ras_ptr - PTR_W'(1);

    // Circular return-address stack. ras_ptr is the next slot to write, so
    // a push on a full stack lands on the oldest entry and the count stays
    // saturated. A pop on an empty stack only records the underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (ras_push) begin
            ras_mem[ras_ptr] <= link_addr;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (ras_count == CNT_W'(RAS_DEPTH)) begin
                ras_overflow <= 1'b1;
            end else begin
                ras_count <= ras_count + CNT_W'(1);
            end
        end else if (ras_pop) begin
            if (ras_count == '0) begin
                ras_underflow <= 1'b1;
            end else begin
                ras_count <= ras_count - CNT_W'(1);
                ras_ptr   <= ras_top;
            end
        end
    end

    assign ret_addr = (ras_count == '0) ? '0 : ras_mem[ras_top];
`else
    logic [ADDR_W-1:0] ret_q;

    // Without the stack, the return target is simply the link address of
    // the most recently committed JAL; RET does not disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q <= '0;
        end else if (ras_push) begin
            ret_q <= link_addr;
        end
    end

    assign ret_addr      = ret_q;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
Registered decode/control stage for the pipelined core. It decodes OPCODE/FUNC in ID and registers the control bundle into the ID/EX boundary. It resolves branches and jumps in EX, squashes the wrong-path instruction, and keeps a parametrised return-address stack (RAS) for JAL/RET. It supersedes the purely combinational decoder by adding stall/flush handshakes, a link-address path and an illegal-instruction flag.

Parameters:
ADDR_W, 16, width of PC and link/return addresses
RAS_DEPTH, 8, return-address stack entries (power of 2, >=2)
ALU_OP_W, 5, width of ALU_OP field

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  ID holds a valid instruction
OPCODE  in  6  [5:4] type (0=R, 2=I, 1=J), [3:0] subOP
FUNC  in  6  R-type function
pc_plus1  in  ADDR_W  PC+1 of the ID instruction
ALU_Z  in  1  ALU zero flag of the instruction in EX
stall  in  1  hold ID/EX register and RAS
out_valid  out  1  EX slot holds a valid instruction
ALU_OP  out  ALU_OP_W  registered ALU operation
RF_WE, DM_WE, A_SEL, B_SEL, DM_ADDR_SEL  out  1 each  registered controls
RD_SEL, RF_D_SEL  out  2 each  registered selects
PC_SEL  out  2  0=PC+1, 1=branch, 2=jump, 3=return
flush  out  1  squash the instruction currently in ID
ret_addr  out  ADDR_W  RAS top (RET target)
link_addr  out  ADDR_W  registered pc_plus1 of EX instruction (JAL writeback)
illegal  out  1  registered: EX instruction undecodable
ras_overflow, ras_underflow  out  1 each  sticky error flags

Behaviour:
- Reset (rst=1 at posedge): every output and internal register is 0. This covers out_valid, all controls, PC_SEL, link_addr, ret_addr, illegal, and both sticky flags. RAS count and pointer are 0. Reset mid-operation discards stack contents.
- Latency is 1 cycle. Decode is captured at posedge when !stall. If !in_valid or flush=1 at that edge, a bubble is captured: out_valid=0, all enables 0, ALU_OP=0.
- stall=1: ID/EX register and RAS hold. PC_SEL is forced to 0, so flush=0.
- R-type: FUNC 0..8 gives RF_WE=1 and ALU_OP=FUNC. Any other FUNC is illegal.
- I-type subOP:
  - 0–6 (ADDI, SUBI, ANDI, ORI, XORI, LUI, LLI): RF_WE=1, B_SEL=1, RD_SEL=1, ALU_OP = 0, 1, 2, 3, 4, 9, 10 respectively.
  - 7 LWR: RF_WE=1, RD_SEL=1, RF_D_SEL=1, ALU_OP=11.
  - 8 SWR: DM_WE=1, ALU_OP=12.
  - 9 LWI: RF_WE=1, B_SEL=1, RD_SEL=1, RF_D_SEL=1, DM_ADDR_SEL=1, ALU_OP=13.
  - 10 SWI: DM_WE=1, DM_ADDR_SEL=1, ALU_OP=14.
  - 11 BEQ and 12 BNE: ALU_OP=1, no write enables.
- J-type subOP:
  - 0 JMP: PC_SEL=2.
  - 1 JAL: RF_WE=1, RD_SEL=2, RF_D_SEL=2, ALU_OP=16, PC_SEL=2.
  - 2 RET: PC_SEL=3, ALU_OP=17.
- Anything else, including OPCODE[5:4]=3, is illegal. An illegal instruction has all enables 0, ALU_OP=0, illegal=1, and out_valid=1.
- PC_SEL is combinational from the EX register and is 0 when !out_valid or stall. BEQ gives 1 when ALU_Z=1; BNE gives 1 when ALU_Z=0; JMP and JAL give 2; RET gives 3.
- flush = (PC_SEL != 0). On the same edge the ID instruction is replaced by a bubble.
- RAS updates at posedge when out_valid && !stall:
  - JAL pushes link_addr.
  - RET pops.
  - Push and pop are never simultaneous.
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH and ras_overflow is set.
  - Pop when empty leaves count at 0 and sets ras_underflow; ret_addr=0 while the stack is empty.
  - ret_addr is the current top entry, combinational.
- Sticky flags clear only on rst.

Optional Feature:
PIPE_CTRL_RAS_EN
- Defined: full RAS as specified.
- Undefined: no stack. ret_addr is a single register loaded by each committing JAL and unchanged by RET. ras_overflow and ras_underflow are tied to 0.

Test Plan:
- rst, then OPCODE=0x20 (ADDI), in_valid=1 -> next cycle out_valid=1, RF_WE=1, B_SEL=1, RD_SEL=1, ALU_OP=0, PC_SEL=0.
- BEQ (0x2B) in EX with ALU_Z=1 -> PC_SEL=1, flush=1; next cycle out_valid=0 despite in_valid=1. Same with ALU_Z=0 -> PC_SEL=0, flush=0.
- JAL (0x11) with pc_plus1=0x0010, then JAL with 0x0020, RET (0x12), RET -> ret_addr 0x0020 at the first RET, 0x0010 at the second.
- RAS_DEPTH=8: JALs with pc_plus1=1..9, then 8 RETs -> targets 9..2, ras_overflow=1. A 9th RET -> ret_addr=0, ras_underflow=1.
- JAL in EX with stall=1 for 3 cycles -> outputs held, PC_SEL=0, flush=0, no push. stall=0 -> exactly one push.
- R-type FUNC=9, then rst asserted with 3 stack entries -> illegal=1 with all enables 0. After rst: count 0, ret_addr=0, flags 0.
